dmux_df: RTL and testbench
==========================

# dmux_df

1-to-4 demultiplexer with enable, routing a single data bit to one of four outputs selected by a 2-bit select. The combinational path gives same-time routing for glue logic. A clocked stage adds a registered copy of the outputs and optional per-channel activity counters for debug and status readout. The block sits between a single-bit source and four per-channel consumers.

## Interface
- SEL_W, 2: select width; output count N = 2**SEL_W (4 at default).
- CNT_W, 8: width of each per-channel activity counter.
- clk  input  1  rising-edge clock for registered outputs and counters.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  data bit to route.
- sel  input  SEL_W  channel select; channel index = unsigned sel.
- en  input  1  enable; 0 forces all outputs low.
- dout  output  N  combinational routed outputs.
- dout_q  output  N  registered copy of dout.
- cnt  output  N*CNT_W  packed per-channel counters; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- dout[i] = en & din & (sel == i), for all i; all other bits 0.
- en=0: dout = 0 regardless of din and sel.
- din=0: dout = 0. Routing a 0 is indistinguishable from disabled; this is intentional.
- dout is one-hot or zero, never multi-hot.
- sel containing X/Z drives dout to X in simulation. No masking is performed.
- Counters, when compiled in: cnt[i] increments by 1 on each clk edge where dout[i]=1.
  - Counters saturate at 2**CNT_W-1 and do not wrap.
  - Counters clear only on rst.

## Timing
- dout: purely combinational, zero latency. It settles within the same delta after any change of din, sel or en.
- dout_q: one clk cycle latency. At each rising edge dout_q <= dout.
- cnt: updates at the rising edge following the cycle in which dout[i]=1.
- Reset (rst=1, asynchronous):
  - dout_q = 0 and cnt = 0 immediately, held while rst is high.
  - dout is unaffected by rst.
- Reset released mid-activity: the first capture occurs at the first rising edge with rst=0.
- Simultaneous rst and clk edge: rst wins.

## Configuration
- DMUX_DF_CNT_EN defined: the per-channel saturating counters are implemented.
- DMUX_DF_CNT_EN undefined:
  - The cnt port remains present and is tied to 0.
  - No counter flops are inferred.
  - dout and dout_q behaviour is identical in both builds.

## Structure
- Shared package dmux_df_pkg holds:
  - default SEL_W and CNT_W constants;
  - a function returning the one-hot decode of sel (N-bit).
- One natural sub-module: dmux_df_cnt, a single saturating CNT_W counter with increment enable. It is instantiated N times via generate when DMUX_DF_CNT_EN is defined.
- The decode and registered output stay in the top module.

## Test plan
- en=1, din=1, sel=00/01/10/11, each held 5 ns -> dout = 0001/0010/0100/1000.
- en=0, din=1, sel=00 -> dout = 0000. Repeat for all sel -> always 0000.
- en=1, din=0, sweep sel -> dout = 0000. dout_q = 0000 one cycle later.
- en=1, din=1, sel=10 for 3 clk cycles, DMUX_DF_CNT_EN defined:
  - dout_q = 0100 after the first edge;
  - cnt channel 2 = 3, all other channels 0.
- Assert rst mid-stream with dout_q=1000 and cnt channel 3 = 5 -> dout_q and cnt go to 0 immediately without a clock edge. dout still follows its inputs.
- CNT_W=8, hold channel 0 active for 300 cycles -> cnt channel 0 saturates at 255.

Source files
------------

// File: rtl/dmux_df_pkg.sv
// rtl/dmux_df_pkg.sv - shared constants and select decode for dmux_df
//
// Purpose : default parameter values and the one-hot select decode used by
//           the dmux_df top.
// Contents: SEL_W_DEF, CNT_W_DEF  default select / counter widths
//           MAX_SEL_W, MAX_N      widest select the decode helper covers
//           dmux_df_decode()      one-hot decode of a select value
package dmux_df_pkg;

  localparam int SEL_W_DEF = 2;
  localparam int CNT_W_DEF = 8;

  // The decode is written once for the widest supported select; callers
  // zero-extend their select and use the low 2**SEL_W bits.
  localparam int MAX_SEL_W = 4;
  localparam int MAX_N     = 2 ** MAX_SEL_W;

  // Equality compare per bit (rather than a shift) so an X/Z select bit
  // propagates X onto the outputs instead of being silently resolved.
  function automatic logic [MAX_N-1:0] dmux_df_decode(input logic [MAX_SEL_W-1:0] s);
    logic [MAX_N-1:0] d;
    d = '0;
    for (int i = 0; i < MAX_N; i++) begin
      d[i] = (s == MAX_SEL_W'(i));
    end
    return d;
  endfunction

endpackage

// File: rtl/dmux_df_cnt.sv
// rtl/dmux_df_cnt.sv - single saturating activity counter
//
// Purpose: counts clock edges on which inc_i is high; holds at all-ones.
// Ports  : clk_i  rising-edge clock
//          rst_i  asynchronous active-high reset, clears the count
//          inc_i  increment request for this cycle
//          cnt_o  current count, CNT_W bits
module dmux_df_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate instead of wrapping so a long-running channel never reads
  // back as quiet.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmux_df.sv
// rtl/dmux_df.sv - 1-to-N demultiplexer with registered copy and counters
//
// Purpose: routes din to one of N = 2**SEL_W outputs chosen by sel when en
//          is high; also provides a registered copy of the outputs and
//          optional per-channel saturating activity counters.
// Macro  : DMUX_DF_CNT_EN - when defined, the counters are built; otherwise
//          cnt is tied to zero and no counter flops exist.
// Ports  : clk     rising-edge clock for dout_q and counters
//          rst     asynchronous active-high reset (dout_q, cnt)
//          din     data bit to route
//          sel     channel select, SEL_W bits
//          en      enable; low forces all outputs low
//          dout    combinational routed outputs, N bits
//          dout_q  dout registered on each rising edge, N bits
//          cnt     packed counters, channel i at [i*CNT_W +: CNT_W]
module dmux_df
  import dmux_df_pkg::*;
#(
  parameter  int SEL_W = SEL_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int N     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N-1:0]     dout,
  output logic [N-1:0]     dout_q,
  output logic [N*CNT_W-1:0] cnt
);

  logic [MAX_N-1:0] dec_full;
  logic             unused_dec;
  logic [N-1:0]     dout_q_q;
  logic [N-1:0]     dout_q_d;

  assign dec_full = dmux_df_decode(MAX_SEL_W'(sel));

  // Bits above N only exist because the decode is sized for MAX_SEL_W.
  assign unused_dec = ^dec_full;

  // Routing a 0 looks the same as being disabled; consumers only see 1s.
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout[i] = en & din & dec_full[i];
    end
  end

  assign dout_q_d = dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q_q <= '0;
    end else begin
      dout_q_q <= dout_q_d;
    end
  end

  assign dout_q = dout_q_q;

`ifdef DMUX_DF_CNT_EN
  for (genvar g = 0; g < N; g++) begin : g_cnt
    dmux_df_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i(clk),
      .rst_i(rst),
      .inc_i(dout[g]),
      .cnt_o(cnt[g*CNT_W +: CNT_W])
    );
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_dmux_df.sv
// tb/tb_dmux_df.sv - directed scoreboard bench for dmux_df
module tb_dmux_df;

  logic        clk;
  logic        rst;
  logic        din;
  logic [1:0]  sel;
  logic        en;
  logic [3:0]  dout;
  logic [3:0]  dout_q;
  logic [31:0] cnt;

  int n_vec;
  int n_bad;

  logic [3:0] q_dout[$];
  logic [3:0] q_dq[$];
  int         exp_cnt[4];

  dmux_df dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .sel   (sel),
    .en    (en),
    .dout  (dout),
    .dout_q(dout_q),
    .cnt   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded 100000 time units");
    $fatal(1);
  end

  function automatic logic [31:0] cnt_model();
    logic [31:0] v;
    v = '0;
`ifdef DMUX_DF_CNT_EN
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(exp_cnt[i]);
`endif
    return v;
  endfunction

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] obs, input bit from_dq);
    logic [3:0] e;
    if (from_dq ? (q_dq.size() == 0) : (q_dout.size() == 0)) begin
      n_vec++;
      n_bad++;
      $error("FAIL %s: observed %b expected <scoreboard empty>", tag, obs);
    end else begin
      e = from_dq ? q_dq.pop_front() : q_dout.pop_front();
      chk4(tag, obs, e);
    end
  endtask

  // One directed vector: drive away from the rising edge, check the
  // combinational output, then check the registered copy and counters.
  task automatic step(input logic e, input logic d, input logic [1:0] s);
    logic [3:0] ex;
    @(negedge clk);
    en = e; din = d; sel = s;
    ex = (e & d) ? (4'b0001 << s) : 4'b0000;
    q_dout.push_back(ex);
    q_dq.push_back(ex);
    #1;
    pop_chk("dout", dout, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (ex[i] && exp_cnt[i] < 255) exp_cnt[i]++;
    end
    #1;
    pop_chk("dout_q", dout_q, 1'b1);
    chk32("cnt", cnt, cnt_model());
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    chk4("rst_dout_q", dout_q, 4'b0000);
    chk32("rst_cnt", cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] tmp;
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    rst = 1'b1; en = 1'b0; din = 1'b0; sel = 2'b00;

    // Reset state, including across a clock edge with rst held.
    #2;
    chk4("reset_dout_q", dout_q, 4'b0000);
    chk32("reset_cnt", cnt, 32'h0);
    @(posedge clk); #1;
    chk4("reset_hold_dout_q", dout_q, 4'b0000);
    chk32("reset_hold_cnt", cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Routing a 1 to each channel.
    for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 2'(s));
    // Disabled: always zero.
    for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 2'(s));
    // Routing a 0: always zero.
    for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 2'(s));
    for (int s = 0; s < 4; s++) step(1'b0, 1'b0, 2'(s));

    // Channel 2 held for three cycles from a clean reset.
    pulse_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 2'b10);
`ifdef DMUX_DF_CNT_EN
    chk32("cnt_ch2_three", cnt, 32'h0003_0000);
`else
    chk32("cnt_tied_zero", cnt, 32'h0);
`endif

    // Asynchronous reset mid-stream with channel 3 active.
    pulse_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 2'b11);
    chk4("pre_rst_dout_q", dout_q, 4'b1000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    chk4("async_rst_dout_q", dout_q, 4'b0000);
    chk32("async_rst_cnt", cnt, 32'h0);
    chk4("rst_dout_follow3", dout, 4'b1000);
    sel = 2'b01;
    #1;
    chk4("rst_dout_follow1", dout, 4'b0010);
    @(posedge clk); #1;
    chk4("rst_held_dout_q", dout_q, 4'b0000);
    chk32("rst_held_cnt", cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // First capture after release.
    step(1'b1, 1'b1, 2'b01);

    // Saturation on channel 0.
    pulse_reset();
    for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 2'b00);
    tmp = cnt;
`ifdef DMUX_DF_CNT_EN
    chk32("cnt_ch0_saturated", tmp, 32'h0000_00FF);
`else
    chk32("cnt_tied_zero_sat", tmp, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
